// File: rtl/sram_controller.sv
// ---------------------------------------------------------------------------
// sram_controller
//   Pipeline-side master for a 16-bit external SRAM. Each 32-bit load/store
//   from the MEM stage is split into a LO and a HI 16-bit access. Each access
//   is held on the bus for WAIT_CYCLES cycles. ready stays low while an access
//   is in flight, which stalls the pipeline.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   wr_en, rd_en     store / load request levels (wr_en has priority)
//   address, wdata   byte address and store data (latched at acceptance)
//   rdata            load data, valid in the cycle ready rises
//   ready            0 = stall
//   SRAM_DQ          bidirectional 16-bit data bus
//   SRAM_ADDR        half-word address, 0 when no access is in progress
//   SRAM_WE_N        write enable, active low
//   SRAM_UB_N/LB_N/CE_N/OE_N  tied active (0)
// ---------------------------------------------------------------------------
module sram_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR_LO = 3'd1,
        WR_HI = 3'd2,
        RD_LO = 3'd3,
        RD_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t      r_state;
    logic [CW-1:0] r_cnt;
    logic [16:0] r_word;
    logic [15:0] r_wdata_hi;
    logic [31:0] r_rdata;
    logic [17:0] r_sram_addr;
    logic        r_we_n;
    logic        r_dq_oe;
    logic [15:0] r_dq_out;

    logic [31:0] w_off;
    logic [16:0] w_word;
    logic        w_last;
    logic        w_unused;

    // Word index wraps modulo 2^17; upper and byte-offset bits are dropped.
    assign w_off    = address - 32'(BASE_ADDR);
    assign w_word   = w_off[18:2];
    assign w_unused = &{1'b0, w_off[31:19], w_off[1:0]};
    assign w_last   = (r_cnt == CW'(WAIT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_word      <= '0;
            r_wdata_hi  <= '0;
            r_rdata     <= '0;
            r_sram_addr <= '0;
            r_we_n      <= 1'b1;
            r_dq_oe     <= 1'b0;
            r_dq_out    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (wr_en) begin
                        r_word      <= w_word;
                        r_wdata_hi  <= wdata[31:16];
                        r_sram_addr <= {w_word, 1'b0};
                        r_dq_out    <= wdata[15:0];
                        r_dq_oe     <= 1'b1;
                        r_we_n      <= 1'b0;
                        r_state     <= WR_LO;
                    end else if (rd_en) begin
                        r_word      <= w_word;
                        r_sram_addr <= {w_word, 1'b0};
                        r_dq_oe     <= 1'b0;
                        r_we_n      <= 1'b1;
                        r_state     <= RD_LO;
                    end
                end
                WR_LO: begin
                    if (w_last) begin
                        r_cnt       <= '0;
                        r_sram_addr <= {r_word, 1'b1};
                        r_dq_out    <= r_wdata_hi;
                        r_state     <= WR_HI;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WR_HI: begin
                    if (w_last) begin
                        r_cnt       <= '0;
                        r_sram_addr <= '0;
                        r_dq_oe     <= 1'b0;
                        r_we_n      <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RD_LO: begin
                    if (w_last) begin
                        // Sample on the last cycle so the SRAM has had the
                        // whole phase to settle.
                        r_rdata[15:0] <= SRAM_DQ;
                        r_cnt         <= '0;
                        r_sram_addr   <= {r_word, 1'b1};
                        r_state       <= RD_HI;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RD_HI: begin
                    if (w_last) begin
                        r_rdata[31:16] <= SRAM_DQ;
                        r_cnt          <= '0;
                        r_sram_addr    <= '0;
                        r_state        <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state     <= IDLE;
                    r_cnt       <= '0;
                    r_sram_addr <= '0;
                    r_we_n      <= 1'b1;
                    r_dq_oe     <= 1'b0;
                end
            endcase
        end
    end

    assign ready     = ((r_state == IDLE) && !wr_en && !rd_en) || (r_state == DONE);
    assign rdata     = r_rdata;
    assign SRAM_DQ   = r_dq_oe ? r_dq_out : 16'hzzzz;
    assign SRAM_ADDR = r_sram_addr;
    assign SRAM_WE_N = r_we_n;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, wdata;
    logic [31:0] rdata;
    logic        ready;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_off  = 1'b1;

    typedef struct packed {
        logic [17:0] addr;
        logic        we_n;
        logic [15:0] dq;
    } beat_t;

    typedef struct packed {
        logic        is_rd;
        logic [31:0] rdata;
    } done_t;

    beat_t beat_q[$];
    done_t done_q[$];

    sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .address   (address),
        .wdata     (wdata),
        .rdata     (rdata),
        .ready     (ready),
        .SRAM_DQ   (SRAM_DQ),
        .SRAM_ADDR (SRAM_ADDR),
        .SRAM_WE_N (SRAM_WE_N),
        .SRAM_UB_N (SRAM_UB_N),
        .SRAM_LB_N (SRAM_LB_N),
        .SRAM_CE_N (SRAM_CE_N),
        .SRAM_OE_N (SRAM_OE_N)
    );

    always #5 clk = ~clk;

    // Small SRAM model: drives the bus whenever not being written.
    logic [15:0] mem [0:255];
    assign SRAM_DQ = (SRAM_WE_N && !SRAM_OE_N && !SRAM_CE_N) ? mem[SRAM_ADDR[7:0]] : 16'hzzzz;
    always @(posedge clk) if (!SRAM_WE_N) mem[SRAM_ADDR[7:0]] <= SRAM_DQ;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Push the expected bus beats and completion, then issue and hold the request.
    task automatic do_req(input bit wr, input bit rd, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rdata);
        logic [31:0] off;
        logic [16:0] word;
        bit          got_ready;
        off  = a - 32'd1024;
        word = off[18:2];
        for (int i = 0; i < W; i++)
            beat_q.push_back(wr ? beat_t'{{word, 1'b0}, 1'b0, d[15:0]} : beat_t'{{word, 1'b0}, 1'b1, 16'h0});
        for (int i = 0; i < W; i++)
            beat_q.push_back(wr ? beat_t'{{word, 1'b1}, 1'b0, d[31:16]} : beat_t'{{word, 1'b1}, 1'b1, 16'h0});
        done_q.push_back(done_t'{!wr, exp_rdata});
        @(posedge clk); #1;
        wr_en = wr; rd_en = rd; address = a; wdata = d;
        got_ready = 1'b0;
        for (int c = 0; c < 50 && !got_ready; c++) begin
            @(negedge clk);
            if (ready) got_ready = 1'b1;
        end
        if (!got_ready) chk("req_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    // Monitor: a run of not-ready cycles is one transaction; the first is the
    // acceptance cycle, the rest are bus beats, the ready cycle completes it.
    int run = 0;
    always @(negedge clk) begin
        if (mon_off) begin
            run = 0;
        end else if (!ready) begin
            if (run > 0) begin
                if (beat_q.size() == 0) chk("beat_unexpected", 32'd1, 32'd0);
                else begin
                    beat_t b;
                    b = beat_q.pop_front();
                    chk("beat_addr", {14'd0, SRAM_ADDR}, {14'd0, b.addr});
                    chk("beat_we_n", {31'd0, SRAM_WE_N}, {31'd0, b.we_n});
                    if (!b.we_n) chk("beat_dq", {16'd0, SRAM_DQ}, {16'd0, b.dq});
                end
            end
            run++;
        end else begin
            if (run > 0) begin
                chk("latency", run, 2 * W + 1);
                if (done_q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
                else begin
                    done_t dn;
                    dn = done_q.pop_front();
                    chk("rdata", rdata, dn.rdata);
                end
            end
            run = 0;
            chk("quiet_we_n", {31'd0, SRAM_WE_N}, 32'd1);
            chk("quiet_addr", {14'd0, SRAM_ADDR}, 32'd0);
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", {31'd0, ready}, 32'd1);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        chk("reset_addr", {14'd0, SRAM_ADDR}, 32'd0);
        mon_off = 1'b0;

        // 1/2: store then load at word 0
        do_req(1, 0, 32'd1024, 32'hDEAD_BEEF, 32'h0);
        idle(2);
        do_req(0, 1, 32'd1024, 32'h0, 32'hDEAD_BEEF);
        idle(2);
        // 3: mapping and wrap
        do_req(1, 0, 32'd1032, 32'hCAFE_F00D, 32'hDEAD_BEEF);
        idle(1);
        do_req(0, 1, 32'd1032, 32'h0, 32'hCAFE_F00D);
        idle(1);
        do_req(1, 0, 32'd1024 + 32'd524288, 32'h0102_0304, 32'hCAFE_F00D);
        idle(1);
        do_req(0, 1, 32'd1024, 32'h0, 32'h0102_0304);
        idle(1);
        // 4: both requests -> write wins, rdata unchanged
        do_req(1, 1, 32'd1032, 32'h5555_AAAA, 32'h0102_0304);
        idle(1);
        do_req(0, 1, 32'd1032, 32'h0, 32'h5555_AAAA);
        // back-to-back store then load, no idle gap
        do_req(1, 0, 32'd1040, 32'h1111_2222, 32'h5555_AAAA);
        do_req(0, 1, 32'd1040, 32'h0, 32'h1111_2222);
        idle(2);

        // 5: reset during WR_LO
        mon_off = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b1; address = 32'd1024; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; wr_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", {31'd0, ready}, 32'd1);
        chk("rst_mid_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        chk("rst_mid_addr", {14'd0, SRAM_ADDR}, 32'd0);
        chk("rst_mid_rdata", rdata, 32'd0);
        mon_off = 1'b0;
        // LO half was partly written before reset, HI half untouched
        do_req(0, 1, 32'd1024, 32'h0, 32'h0102_5678);

        // 6: quiet idle
        idle(20);

        repeat (3) @(posedge clk);
        chk("beat_q_empty", beat_q.size(), 32'd0);
        chk("done_q_empty", done_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
